fifo_wr_arbiter: RTL and testbench

- Shares one write port of the team's single-clock FIFO among NUM_REQ producers.
- Round-robin arbitration with burst locking: a granted producer keeps the port for up to MAX_BURST beats.
- Registered write strobe/data toward the FIFO.
- Sits between producer blocks and the FIFO. Uses the FIFO's free-slot count so it never overruns it.

---
 rtl/fifo_wr_arbiter_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
// Used by fifo_wr_arbiter and rr_pick.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

    // Index width for n requesters; never narrower than one bit.
    function automatic int REQ_IDX_W(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: rotates the valid vector so i_ptr is at bit 0, takes the lowest set bit,
// then maps that offset back to an absolute index. Purely combinational.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    localparam int             SW  = IW + 1;
    localparam logic [SW-1:0]  N_W = SW'(N);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [SW-1:0]  w_sum;

    assign w_dbl = {i_valid, i_valid};
    assign w_rot = w_dbl[i_ptr +: N];

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        o_found = 1'b0;
        w_off   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                o_found = 1'b1;
                w_off   = IW'(j);
            end
        end
    end

    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = (w_sum >= N_W) ? IW'(w_sum - N_W) : IW'(w_sum);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional stall statistics (stats_clear / stall_cycles) are built when FIFO_WR_ARBITER_STATS_EN is defined.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_BURST  = 8
) (
    input  logic                            clock,
    input  logic                            aresetn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]        req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [ADDR_WIDTH:0]             fifo_free,
    output logic                            fifo_wr_en,
    output logic [WIDTH-1:0]                fifo_wr_data,
    output logic [REQ_IDX_W(NUM_REQ)-1:0]   grant_id,
    output logic                            busy
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    input  logic                            stats_clear,
    output logic [STALL_CNT_W-1:0]          stall_cycles
`endif
);

    localparam int                IW         = REQ_IDX_W(NUM_REQ);
    localparam int                CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(MAX_BURST);
    localparam logic [IW-1:0]     LAST_IDX   = IW'(NUM_REQ - 1);

    arb_state_t        r_state;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_grant_id;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_wr_en;
    logic [WIDTH-1:0]  r_wr_data;

    logic              w_pick_found;
    logic [IW-1:0]     w_pick_idx;
    logic              w_space_ok;
    logic [IW-1:0]     w_sel_idx;
    logic              w_sel_valid;
    logic              w_ready_sel;
    logic              w_accept;
    logic [WIDTH-1:0]  w_sel_data;
    logic [CNT_W-1:0]  w_cnt_inc;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    // The registered strobe is a write fifo_free does not reflect yet.
    assign w_space_ok  = fifo_free > {{ADDR_WIDTH{1'b0}}, r_wr_en};

    assign w_sel_idx   = (r_state == BURST) ? r_grant_id : w_pick_idx;
    assign w_sel_valid = (r_state == BURST) ? req_valid[r_grant_id] : w_pick_found;
    assign w_ready_sel = aresetn && w_space_ok && ((r_state == BURST) || w_pick_found);
    assign w_accept    = w_ready_sel && w_sel_valid;
    assign w_sel_data  = req_data[w_sel_idx*WIDTH +: WIDTH];
    assign w_cnt_inc   = r_beat_cnt + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_ready_sel) begin
            req_ready[w_sel_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_data <= w_sel_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_grant_id <= w_pick_idx;
                        r_beat_cnt <= CNT_W'(1);
                        if (MAX_BURST > 1) begin
                            r_state <= BURST;
                        end else begin
                            r_rr_ptr <= wrap_inc(w_pick_idx);
                        end
                    end
                end
                BURST: begin
                    if (w_accept) begin
                        if (w_cnt_inc == BURST_LAST) begin
                            r_state    <= IDLE;
                            r_rr_ptr   <= wrap_inc(r_grant_id);
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= w_cnt_inc;
                        end
                    end else if (!req_valid[r_grant_id]) begin
                        // Owner went quiet: give up the rest of the burst.
                        r_state    <= IDLE;
                        r_rr_ptr   <= wrap_inc(r_grant_id);
                        r_beat_cnt <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state == BURST);

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            r_stall_cycles <= '0;
        end else if (stats_clear) begin
            r_stall_cycles <= '0;
        end else if ((|req_valid) && !w_space_ok && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector tables, a mid-burst reset sequence,
// and random traffic compared against a transaction-level model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int WIDTH      = 32;
    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 5;
    localparam int MAX_BURST  = 8;
    localparam int RND_CYCLES = 3000;

    logic                     clock = 1'b0;
    logic                     aresetn = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [ADDR_WIDTH:0]      fifo_free = '0;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_wr_data;
    logic [1:0]               grant_id;
    logic                     busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic                     stats_clear = 1'b0;
    logic [15:0]              stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    fifo_wr_arbiter #(
        .WIDTH      (WIDTH),
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clock        (clock),
        .aresetn      (aresetn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_free    (fifo_free),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
        ,
        .stats_clear  (stats_clear),
        .stall_cycles (stall_cycles)
`endif
    );

    typedef struct {
        logic        rst_before;
        logic [3:0]  valid;
        logic [5:0]  free;
        logic [3:0]  exp_ready;
        logic        exp_wr;
        logic [31:0] exp_data;
        logic        exp_busy;
        logic [1:0]  exp_grant;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] tag(input int i);
        return 32'hA000_0000 + (32'(i) << 24);
    endfunction

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [5:0] f,
                                input logic [3:0] r, input logic w, input int own,
                                input logic b, input logic [1:0] g);
        vec_t x;
        x.rst_before = rst; x.valid = v; x.free = f; x.exp_ready = r;
        x.exp_wr = w; x.exp_data = tag(own); x.exp_busy = b; x.exp_grant = g;
        return x;
    endfunction

    task automatic set_tag_data();
        for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = tag(i);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        aresetn   = 1'b0;
        req_valid = '0;
        fifo_free = '0;
        repeat (2) @(negedge clock);
        aresetn = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        if (v.rst_before) apply_reset();
        @(negedge clock);
        req_valid = v.valid;
        fifo_free = v.free;
        #1 check({nm, "_ready"}, 32'(req_ready), 32'(v.exp_ready));
        @(posedge clock);
        #1;
        check({nm, "_wr_en"}, 32'(fifo_wr_en), 32'(v.exp_wr));
        if (v.exp_wr) check({nm, "_data"}, fifo_wr_data, v.exp_data);
        check({nm, "_busy"}, 32'(busy), 32'(v.exp_busy));
        check({nm, "_grant"}, 32'(grant_id), 32'(v.exp_grant));
    endtask

    // Random-phase stimulus and reference state.
    logic [3:0]  pv;
    logic [31:0] pd[NUM_REQ];
    logic [3:0]  last_acc;
    int          m_owner, m_ptr, m_grant, m_beats;
    logic        m_wr;
    logic [31:0] m_data;

    initial begin
        int owner, beat, cand, r;
        logic       space, acc;
        logic [3:0] exp_ready;

        // Reset with everything requesting.
        set_tag_data();
        aresetn   = 1'b0;
        req_valid = 4'hF;
        fifo_free = 6'd32;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clock);
        aresetn = 1'b1;
        #1 check("first_ready", 32'(req_ready), 32'h1);
        @(posedge clock);
        #1;
        check("first_wr_en", 32'(fifo_wr_en), 32'h1);
        check("first_data", fifo_wr_data, 32'hA000_0000);
        check("first_grant", 32'(grant_id), 32'h0);

        // Round robin with all four valid: 8 beats each from 0,1,2,3, then 0 again.
        for (int k = 0; k < 33; k++) begin
            owner = (k / MAX_BURST) % NUM_REQ;
            beat  = (k % MAX_BURST) + 1;
            vecs.push_back(mk(k == 0, 4'hF, 6'd32, 4'(1 << owner), 1'b1, owner,
                              beat != MAX_BURST, 2'(owner)));
        end
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], "rr");
        vecs.delete();

        // Producer 2 alone while fifo_free dips to zero.
        vecs.push_back(mk(1'b1, 4'b0100, 6'd32, 4'b0100, 1'b1, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd32, 4'b0100, 1'b1, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd0,  4'b0000, 1'b0, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd2,  4'b0100, 1'b1, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd2,  4'b0100, 1'b1, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd1,  4'b0000, 1'b0, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd0,  4'b0000, 1'b0, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd0,  4'b0000, 1'b0, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd1,  4'b0100, 1'b1, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd32, 4'b0100, 1'b1, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd32, 4'b0100, 1'b1, 2, 1'b1, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd32, 4'b0100, 1'b1, 2, 1'b0, 2'd2));
        vecs.push_back(mk(1'b0, 4'b0100, 6'd32, 4'b0100, 1'b1, 2, 1'b1, 2'd2));
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], "stall");
        vecs.delete();

        // Producer 1 gives up after 3 beats; producer 3 takes over with a full burst.
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(k == 0, 4'b1010, 6'd32, 4'b0010, 1'b1, 1, 1'b1, 2'd1));
        vecs.push_back(mk(1'b0, 4'b1000, 6'd32, 4'b0010, 1'b0, 1, 1'b0, 2'd1));
        for (int k = 1; k <= MAX_BURST; k++)
            vecs.push_back(mk(1'b0, 4'b1000, 6'd32, 4'b1000, 1'b1, 3, k != MAX_BURST, 2'd3));
        vecs.push_back(mk(1'b0, 4'b1010, 6'd32, 4'b0010, 1'b1, 1, 1'b1, 2'd1));
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], "drop");
        vecs.delete();

        // Reset during beat 5 of producer 2's burst; pointer must restart from 0.
        apply_reset();
        for (int k = 1; k <= MAX_BURST; k++)
            run_vec(mk(1'b0, 4'b0110, 6'd32, 4'b0010, 1'b1, 1, k != MAX_BURST, 2'd1), "mid_p1");
        for (int k = 1; k <= 5; k++)
            run_vec(mk(1'b0, 4'b0110, 6'd32, 4'b0100, 1'b1, 2, 1'b1, 2'd2), "mid_p2");
        #1 aresetn = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        @(negedge clock);
        aresetn = 1'b1;
        #1 check("post_rst_ready", 32'(req_ready), 32'b0010);
        @(posedge clock);
        #1;
        check("post_rst_grant", 32'(grant_id), 32'h1);
        check("post_rst_data", fifo_wr_data, tag(1));

        // Random traffic against the reference model.
        apply_reset();
        pv = '0; last_acc = '0;
        for (int i = 0; i < NUM_REQ; i++) pd[i] = '0;
        m_owner = -1; m_ptr = 0; m_grant = 0; m_beats = 0; m_wr = 1'b0; m_data = '0;
        for (int cyc = 0; cyc < RND_CYCLES; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (pv[i] && last_acc[i]) begin
                    pv[i] = ($urandom_range(0, 3) != 0);
                    pd[i] = $urandom;
                end else if (!pv[i]) begin
                    pv[i] = ($urandom_range(0, 2) == 0);
                    pd[i] = $urandom;
                end
            end
            r = $urandom_range(0, 5);
            @(negedge clock);
            req_valid = pv;
            for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = pd[i];
            fifo_free = (r <= 2) ? 6'(r) : 6'($urandom_range(0, 32));

            space = int'(fifo_free) > int'(m_wr);
            cand  = m_owner;
            if (m_owner < 0) begin
                for (int k = NUM_REQ - 1; k >= 0; k--)
                    if (pv[(m_ptr + k) % NUM_REQ]) cand = (m_ptr + k) % NUM_REQ;
            end
            exp_ready = (cand >= 0 && space) ? 4'(1 << cand) : 4'h0;
            #1 check("rnd_ready", 32'(req_ready), 32'(exp_ready));
            acc      = (cand >= 0) && space && pv[cand];
            last_acc = acc ? 4'(1 << cand) : 4'h0;

            m_wr = acc;
            if (acc) m_data = pd[cand];
            if (m_owner < 0) begin
                if (acc) begin
                    m_grant = cand;
                    m_beats = 1;
                    if (MAX_BURST > 1) m_owner = cand;
                    else m_ptr = (cand + 1) % NUM_REQ;
                end
            end else if ((acc && (m_beats + 1 == MAX_BURST)) || (!acc && !pv[m_owner])) begin
                m_ptr   = (m_owner + 1) % NUM_REQ;
                m_owner = -1;
                m_beats = 0;
            end else if (acc) begin
                m_beats++;
            end

            @(posedge clock);
            #1;
            check("rnd_wr_en", 32'(fifo_wr_en), 32'(m_wr));
            if (m_wr) check("rnd_data", fifo_wr_data, m_data);
            check("rnd_busy", 32'(busy), 32'(m_owner >= 0));
            check("rnd_grant", 32'(grant_id), 32'(m_grant));
        end

`ifdef FIFO_WR_ARBITER_STATS_EN
        apply_reset();
        check("stats_reset", 32'(stall_cycles), 32'h0);
        req_valid = 4'hF;
        fifo_free = 6'd0;
        repeat (20) @(posedge clock);
        #1 check("stats_count", 32'(stall_cycles), 32'd20);
        @(negedge clock);
        stats_clear = 1'b1;
        @(posedge clock);
        #1 check("stats_clear", 32'(stall_cycles), 32'h0);
        @(negedge clock);
        stats_clear = 1'b0;
        req_valid   = '0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
